// File: rtl/dcache_miss_ctrl_if.sv
// Handshake bundle between the data-cache miss sequencer, the MEM stage/cache array
// and the data-side main-memory port.
interface dcache_miss_ctrl_if;
   logic        req_valid;
   logic        req_write;
   logic [31:0] req_addr;
   logic        hit;
   logic        victim_dirty;
   logic [31:0] victim_addr;
   logic        stall;
   logic        cache_we;
   logic        cache_fill_sel;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic        mem_ready;

   modport master (
      input  req_valid, req_write, req_addr, hit, victim_dirty, victim_addr, mem_ready,
      output stall, cache_we, cache_fill_sel, mem_req, mem_we, mem_addr
   );

   modport slave (
      output req_valid, req_write, req_addr, hit, victim_dirty, victim_addr, mem_ready,
      input  stall, cache_we, cache_fill_sel, mem_req, mem_we, mem_addr
   );
endinterface

// File: rtl/dcache_miss_ctrl.sv
// Miss sequencer for the direct-mapped write-back data cache: stall, victim writeback,
// line refill, commit. Optional saturating performance counters under DCACHE_MISS_CNT_EN.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_IDLE      | serving hits; a miss stalls and latches the access
// S_WRITEBACK | writing the dirty victim word to memory
// S_FILL      | reading the missed line from memory into the cache
// S_COMMIT    | pipeline released; replays the store (if any) into the line
module dcache_miss_ctrl #(
   parameter int CNT_W = 16
) (
   input  logic                  clk,
   input  logic                  rst_b,
   dcache_miss_ctrl_if.master    bus,
   output logic [CNT_W-1:0]      miss_count,
   output logic [CNT_W-1:0]      wb_count
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_WRITEBACK = 2'd1,
      S_FILL      = 2'd2,
      S_COMMIT    = 2'd3
   } state_t;

   state_t      state, state_nx;
   logic [31:0] line_q;
   logic [31:0] victim_q;
   logic        write_q;
   logic        miss_start;
   logic        wb_done;
   logic        fill_done;

   assign miss_start = (state == S_IDLE) && bus.req_valid && !bus.hit;
   assign wb_done    = (state == S_WRITEBACK) && bus.mem_ready;
   assign fill_done  = (state == S_FILL) && bus.mem_ready;

   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Full addresses are kept; the byte offset is masked off when driven to memory.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         line_q   <= '0;
         victim_q <= '0;
         write_q  <= 1'b0;
      end else if (miss_start) begin
         line_q   <= bus.req_addr;
         victim_q <= bus.victim_addr;
         write_q  <= bus.req_write;
      end
   end

   always_comb begin
      state_nx = state;
      case (state)
         S_IDLE: begin
            if (miss_start) begin
               state_nx = bus.victim_dirty ? S_WRITEBACK : S_FILL;
            end
         end
         S_WRITEBACK: begin
            if (bus.mem_ready) begin
               state_nx = S_FILL;
            end
         end
         S_FILL: begin
            if (bus.mem_ready) begin
               state_nx = S_COMMIT;
            end
         end
         S_COMMIT: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   always_comb begin
      bus.stall          = 1'b0;
      bus.cache_we       = 1'b0;
      bus.cache_fill_sel = 1'b0;
      bus.mem_req        = 1'b0;
      bus.mem_we         = 1'b0;
      bus.mem_addr       = '0;
      case (state)
         S_IDLE: begin
            bus.stall    = bus.req_valid && !bus.hit;
            bus.cache_we = bus.req_valid && bus.hit && bus.req_write;
         end
         S_WRITEBACK: begin
            bus.stall    = 1'b1;
            bus.mem_req  = 1'b1;
            bus.mem_we   = 1'b1;
            bus.mem_addr = victim_q & 32'hFFFF_FFFC;
         end
         S_FILL: begin
            bus.stall          = 1'b1;
            bus.mem_req        = 1'b1;
            bus.mem_addr       = line_q & 32'hFFFF_FFFC;
            bus.cache_we       = bus.mem_ready;
            bus.cache_fill_sel = bus.mem_ready;
         end
         S_COMMIT: begin
            bus.cache_we = write_q;
         end
         default: begin
            bus.stall = 1'b0;
         end
      endcase
   end

`ifdef DCACHE_MISS_CNT_EN
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         miss_count <= '0;
         wb_count   <= '0;
      end else begin
         if (fill_done && (miss_count != {CNT_W{1'b1}})) begin
            miss_count <= miss_count + 1'b1;
         end
         if (wb_done && (wb_count != {CNT_W{1'b1}})) begin
            wb_count <= wb_count + 1'b1;
         end
      end
   end
`else
   logic unused_done;
   assign unused_done = wb_done ^ fill_done;
   assign miss_count  = '0;
   assign wb_count    = '0;
`endif

endmodule
